// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall control for the 5-stage core: drives the PC and pipeline
// register load/flush enables and counts stall cycles for performance debug.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_wait
);

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic lu, br_eff;
  logic pc_ld, ifid_ld, idex_ld, exmem_ld, ifid_fl, idex_fl;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      pend_q         <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MEMWAIT;
          pend_d  = branch_taken;
        end else begin
          pend_d  = 1'b0;
        end
      end
      MEMWAIT: begin
        if (mem_busy) begin
          pend_d  = pend_q | branch_taken;
        end else begin
          state_d = RUN;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
        pend_d  = 1'b0;
      end
    endcase
  end

  // A pending branch only exists in MEMWAIT and is honoured on the exit cycle.
  always_comb begin
    lu = idex_mem_read && (idex_rd != '0) &&
         ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
    br_eff = branch_taken || ((state_q == MEMWAIT) && pend_q);
  end

  always_comb begin
    pc_ld    = 1'b0;
    ifid_ld  = 1'b0;
    idex_ld  = 1'b0;
    exmem_ld = 1'b0;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    if (!mem_busy) begin
      if (br_eff) begin
        pc_ld    = 1'b1;
        ifid_ld  = 1'b1;
        idex_ld  = 1'b1;
        exmem_ld = 1'b1;
        ifid_fl  = 1'b1;
        idex_fl  = 1'b1;
      end else if (lu) begin
        idex_ld  = 1'b1;
        idex_fl  = 1'b1;
        exmem_ld = 1'b1;
      end else begin
        pc_ld    = 1'b1;
        ifid_ld  = 1'b1;
        idex_ld  = 1'b1;
        exmem_ld = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = pc_ld ? stall_cycles_q : sat_inc(stall_cycles_q);
  end

  // Enables are forced low for the whole time reset is held.
  assign pc_load      = ~rst & pc_ld;
  assign ifid_load    = ~rst & ifid_ld;
  assign idex_load    = ~rst & idex_ld;
  assign exmem_load   = ~rst & exmem_ld;
  assign ifid_flush   = ~rst & ifid_fl;
  assign idex_flush   = ~rst & idex_fl;
  assign stall_cycles = stall_cycles_q;
  assign mem_wait     = (state_q == MEMWAIT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised plus directed bench for pipe_hazard_ctrl against a cycle-level
// reference model of the hazard rules (counter width 4 to reach saturation).
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             idex_mem_read;
  logic [REG_W-1:0] idex_rd, ifid_rs1, ifid_rs2;
  logic             ifid_uses_rs2, branch_taken, mem_busy;
  logic             pc_load, ifid_load, idex_load, exmem_load;
  logic             ifid_flush, idex_flush, mem_wait;
  logic [CNT_W-1:0] stall_cycles;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
    .exmem_load(exmem_load), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_cycles(stall_cycles), .mem_wait(mem_wait)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_no   = 0;

  // Reference model: "frozen waiting for memory", "branch owed", stall count.
  bit m_wait, m_pend;
  int m_cnt;
  bit e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic model_outputs();
    bit hit, redirect;
    hit = idex_mem_read && idex_rd != 0 &&
          (idex_rd == ifid_rs1 || (ifid_uses_rs2 && idex_rd == ifid_rs2));
    redirect = branch_taken || (m_wait && m_pend);
    {e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf} = 6'b000000;
    if (rst || mem_busy) return;
    if (redirect)      {e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf} = 6'b111111;
    else if (hit)      {e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf} = 6'b001101;
    else               {e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf} = 6'b111100;
  endtask

  task automatic compare_all();
    chk("pc_load",    pc_load,    e_pc);
    chk("ifid_load",  ifid_load,  e_ifid);
    chk("idex_load",  idex_load,  e_idex);
    chk("exmem_load", exmem_load, e_exmem);
    chk("ifid_flush", ifid_flush, e_iff);
    chk("idex_flush", idex_flush, e_idf);
    chk("mem_wait",   mem_wait,   m_wait);
    chk("stall_cycles", stall_cycles, m_cnt);
  endtask

  // One clock: drive inputs, check at the falling edge, advance model at rising edge.
  task automatic cyc(input bit mr, input int rd, input int rs1, input int rs2,
                     input bit u2, input bit br, input bit busy);
    idex_mem_read = mr;
    idex_rd       = REG_W'(rd);
    ifid_rs1      = REG_W'(rs1);
    ifid_rs2      = REG_W'(rs2);
    ifid_uses_rs2 = u2;
    branch_taken  = br;
    mem_busy      = busy;
    @(negedge clk);
    model_outputs();
    compare_all();
    @(posedge clk);
    if (!e_pc && m_cnt < CNT_MAX) m_cnt++;
    if (busy) begin
      m_pend = m_wait ? (m_pend | br) : br;
      m_wait = 1'b1;
    end else begin
      m_pend = 1'b0;
      m_wait = 1'b0;
    end
    cyc_no++;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted between clock edges, held across one edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_wait",   mem_wait,     0);
    chk("rst_stall",      stall_cycles, 0);
    chk("rst_loads",      {pc_load, ifid_load, idex_load, exmem_load}, 0);
    chk("rst_flushes",    {ifid_flush, idex_flush}, 0);
    m_wait = 0; m_pend = 0; m_cnt = 0;
    {idex_mem_read, idex_rd, ifid_rs1, ifid_rs2} = '0;
    {ifid_uses_rs2, branch_taken, mem_busy} = '0;
    @(negedge clk);
    model_outputs();
    compare_all();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {idex_mem_read, idex_rd, ifid_rs1, ifid_rs2} = '0;
    {ifid_uses_rs2, branch_taken, mem_busy} = '0;
    m_wait = 0; m_pend = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Load-use on rs1, then hazard removed
    cyc(1, 5, 5, 0, 0, 0, 0);
    chk("lu_cnt", stall_cycles, 1);
    idle();
    // Filters: x0 destination, rs2 ignored, rs2 used
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 1, 7, 0, 0, 0);
    chk("rs2_unused_cnt", stall_cycles, 1);
    cyc(1, 7, 1, 7, 1, 0, 0);
    chk("rs2_used_cnt", stall_cycles, 2);
    // Branch squashes the load-use
    cyc(1, 5, 5, 0, 0, 1, 0);
    chk("br_lu_cnt", stall_cycles, 2);
    // Memory wait with branch in first busy cycle
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("mw_state", mem_wait, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("mw_cnt", stall_cycles, 5);
    idle();
    chk("mw_exit_flush_seen", {e_pc, e_iff, e_idf}, 3'b111);
    chk("mw_exit_state", mem_wait, 0);
    idle();
    // Saturation
    repeat (20) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("sat_cnt", stall_cycles, 15);
    idle();
    // Reset in MEMWAIT with a branch owed
    cyc(0, 0, 0, 0, 0, 1, 1);
    do_reset();
    idle();
    chk("post_rst_pc", e_pc && !e_iff && !e_idf, 1);

    // Random traffic with periodic resets
    for (int i = 0; i < 600; i++) begin
      if (i % 80 == 79) do_reset();
      cyc($urandom % 2, $urandom % 4, $urandom % 4, $urandom % 4,
          $urandom % 2, ($urandom % 4) == 0, ($urandom % 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
